// File: rtl/sysu_nand2_arb_pkg.sv
// Shared types and self-test constants for the round-robin NAND2 arbiter.
package sysu_arb_pkg;

    typedef enum logic [1:0] {
        S_TEST,
        S_IDLE,
        S_SETTLE
    } state_e;

    // Expected NAND result, indexed by {A,B}
    localparam logic [3:0] NAND_EXP = 4'b0111;
    localparam int         NUM_VEC  = 4;

endpackage

// File: rtl/sysu_nand2_arb_if.sv
// Requester-side bundle of the arbiter: requests/operands in, grant/result out.
interface sysu_nand2_arb_if #(
    parameter int N = 4
);
    localparam int IW = $clog2(N);

    logic [N-1:0]  REQ;
    logic [N-1:0]  A_IN;
    logic [N-1:0]  B_IN;
    logic [N-1:0]  GNT;
    logic          VALID;
    logic          Y_OUT;
    logic [IW-1:0] ID;
    logic          READY;
    logic          FAIL;

    modport master (output REQ, A_IN, B_IN,
                    input  GNT, VALID, Y_OUT, ID, READY, FAIL);
    modport slave  (input  REQ, A_IN, B_IN,
                    output GNT, VALID, Y_OUT, ID, READY, FAIL);

endinterface

// File: rtl/sysu_nand2.sv
// Two-input NAND from the gate library; Delay is a nominal propagation figure only.
module sysu_nand2 #(
    parameter int Delay = 0
) (
    input  logic A,
    input  logic B,
    output logic Y
);

    assign Y = ~(A & B);

    if (Delay < 0) begin : g_bad_delay
        $error("sysu_nand2: Delay must be >= 0");
    end

endmodule

// File: rtl/sysu_nand2_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, modulo N.
module sysu_rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        int j;
        j   = 0;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr) + i) % N;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/sysu_nand2_arb.sv
// Round-robin sequencer time-sharing one sysu_nand2 among N requesters.
// Define SYSU_NAND2_ARB_SELFTEST_EN to add the post-reset gate self-test.
module sysu_nand2_arb
    import sysu_arb_pkg::*;
#(
    parameter int N          = 4,
    parameter int SETTLE     = 2,
    parameter int GATE_DELAY = 0
) (
    input  logic             CLK,
    input  logic             RST,
    sysu_nand2_arb_if.slave  bus
);

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(SETTLE + 1);

    if (SETTLE < 1 || N < 2) begin : g_bad_cfg
        $error("sysu_nand2_arb: need SETTLE >= 1 and N >= 2");
    end

    state_e        st, st_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [IW-1:0] ptr, ptr_nx;
    logic [IW-1:0] own, own_nx;
    logic          op_a, op_a_nx, op_b, op_b_nx;
    logic [N-1:0]  gnt, gnt_nx;
    logic          vld, vld_nx;
    logic          y_q, y_nx;
    logic [IW-1:0] id_q, id_nx;

    logic [N-1:0]  pk_gnt;
    logic [IW-1:0] pk_idx;
    logic          pk_any;
    logic          gate_y;

    sysu_rr_pick #(.N(N), .IW(IW)) u_pick (
        .req (bus.REQ),
        .ptr (ptr),
        .gnt (pk_gnt),
        .idx (pk_idx),
        .any (pk_any)
    );

    // The one shared gate; its inputs only ever come from the operand registers
    sysu_nand2 #(.Delay(GATE_DELAY)) u_gate (
        .A (op_a),
        .B (op_b),
        .Y (gate_y)
    );

`ifdef SYSU_NAND2_ARB_SELFTEST_EN
    logic [1:0] tv, tv_nx;
    logic       fail_q, fail_nx;
    localparam state_e ST_RST  = S_TEST;
    localparam int     CNT_RST = SETTLE;
`else
    localparam state_e ST_RST  = S_IDLE;
    localparam int     CNT_RST = 0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            st   <= ST_RST;
            cnt  <= CW'(CNT_RST);
            ptr  <= '0;
            own  <= '0;
            op_a <= 1'b0;
            op_b <= 1'b0;
            gnt  <= '0;
            vld  <= 1'b0;
            y_q  <= 1'b0;
            id_q <= '0;
`ifdef SYSU_NAND2_ARB_SELFTEST_EN
            tv     <= '0;
            fail_q <= 1'b0;
`endif
        end else begin
            st   <= st_nx;
            cnt  <= cnt_nx;
            ptr  <= ptr_nx;
            own  <= own_nx;
            op_a <= op_a_nx;
            op_b <= op_b_nx;
            gnt  <= gnt_nx;
            vld  <= vld_nx;
            y_q  <= y_nx;
            id_q <= id_nx;
`ifdef SYSU_NAND2_ARB_SELFTEST_EN
            tv     <= tv_nx;
            fail_q <= fail_nx;
`endif
        end
    end

    always_comb begin
        st_nx   = st;
        cnt_nx  = cnt;
        ptr_nx  = ptr;
        own_nx  = own;
        op_a_nx = op_a;
        op_b_nx = op_b;
        gnt_nx  = gnt;
        vld_nx  = 1'b0;
        y_nx    = y_q;
        id_nx   = id_q;
`ifdef SYSU_NAND2_ARB_SELFTEST_EN
        tv_nx   = tv;
        fail_nx = fail_q;
`endif
        case (st)
            S_IDLE: begin
                if (pk_any) begin
                    own_nx  = pk_idx;
                    op_a_nx = bus.A_IN[pk_idx];
                    op_b_nx = bus.B_IN[pk_idx];
                    gnt_nx  = pk_gnt;
                    cnt_nx  = CW'(SETTLE - 1);
                    st_nx   = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt != '0) begin
                    cnt_nx = cnt - 1'b1;
                end else begin
                    y_nx   = gate_y;
                    id_nx  = own;
                    vld_nx = 1'b1;
                    gnt_nx = '0;
                    // Explicit wrap: N need not be a power of two
                    ptr_nx = (own == IW'(N - 1)) ? '0 : own + 1'b1;
                    st_nx  = S_IDLE;
                end
            end
`ifdef SYSU_NAND2_ARB_SELFTEST_EN
            S_TEST: begin
                if (cnt != '0) begin
                    cnt_nx = cnt - 1'b1;
                end else begin
                    if (gate_y != NAND_EXP[{op_a, op_b}]) fail_nx = 1'b1;
                    if (tv == 2'(NUM_VEC - 1)) begin
                        st_nx = S_IDLE;
                    end else begin
                        tv_nx              = tv + 1'b1;
                        {op_a_nx, op_b_nx} = tv + 1'b1;
                        cnt_nx             = CW'(SETTLE);
                    end
                end
            end
`endif
            default: st_nx = S_IDLE;
        endcase
    end

    assign bus.GNT   = gnt;
    assign bus.VALID = vld;
    assign bus.Y_OUT = y_q;
    assign bus.ID    = id_q;
    assign bus.READY = (st == S_IDLE);
`ifdef SYSU_NAND2_ARB_SELFTEST_EN
    assign bus.FAIL  = fail_q;
`else
    assign bus.FAIL  = 1'b0;
`endif

endmodule

// File: doc/sysu_nand2_arb.md
# sysu_nand2_arb

Round-robin arbiter and sequencer that shares one `sysu_nand2` gate instance among `N` requesters. Each granted request has its operands latched and driven onto the shared gate. The block then waits a fixed settle interval and returns the captured result tagged with the requester ID. It sits between lab-level stimulus sources and the 74-series gate library, so several test channels can time-share one physical or simulated gate.

## Interface
- `N`, 4: number of requesters, ≥2.
- `SETTLE`, 2: clock cycles operands are held on the gate before `Y` is sampled, ≥1.
- `GATE_DELAY`, 0: passed to the shared `sysu_nand2` `Delay` parameter.

Ports:
- `CLK` in 1: single clock, all state on rising edge.
- `RST` in 1: synchronous, active-high reset.
- `REQ` in N: per-requester request level.
- `A_IN` in N: per-requester operand A.
- `B_IN` in N: per-requester operand B.
- `GNT` out N: one-hot grant, held while the granted operation is in flight.
- `VALID` out 1: one-cycle pulse, `Y_OUT`/`ID` valid.
- `Y_OUT` out 1: captured gate result.
- `ID` out $clog2(N): index of the requester that owns `Y_OUT`.
- `READY` out 1: high in IDLE.
- `FAIL` out 1: sticky self-test failure (see Configuration).

## Operation
- Reset values (at any edge with `RST`=1): `GNT`=0, `VALID`=0, `Y_OUT`=0, `ID`=0, `FAIL`=0, operand regs=0, pointer `PTR`=0. Next state is TEST if compiled in, else IDLE.
- Reset has priority over everything. An in-flight operation is discarded and no `VALID` is issued for it.
- States:
  - TEST (optional).
  - IDLE: `READY`=1.
  - SETTLE: `READY`=0, counter `cnt` of width $clog2(SETTLE+1).
- IDLE, on an edge where any `REQ` bit is 1:
  - Winner w = first set bit scanning `PTR`, `PTR`+1, … modulo N.
  - Latch `A_IN[w]`, `B_IN[w]` into the operand regs.
  - `GNT`=1<<w, `cnt`=SETTLE-1, go to SETTLE.
- IDLE with no request: no change.
- SETTLE, `cnt`≠0: decrement `cnt`; operands held.
- SETTLE, `cnt`=0:
  - `Y_OUT`=gate `Y`, `ID`=w, `VALID`=1, `GNT`=0.
  - `PTR`=(w+1) mod N, with wrap N-1→0.
  - Go to IDLE.
- `VALID` self-clears on the following edge.
- Requests are level-sensitive. `REQ`/`A_IN`/`B_IN` changes during SETTLE do not affect the in-flight operation. A requester dropping `REQ` mid-operation still receives its `VALID`.
- A requester still asserting `REQ` after its `VALID` is re-arbitrated normally. It gets lowest priority because of the `PTR` rotation.
- `SETTLE`<1 or `N`<2 is illegal: elaboration-time check/`$error`.

## Timing
- Request sampled at edge k → `GNT` high from edge k through edge k+SETTLE. Capture happens at edge k+SETTLE, so `VALID` is high for the cycle following edge k+SETTLE.
- Latency from sampling edge to `VALID`: SETTLE cycles.
- Earliest next grant is at edge k+SETTLE+1, giving throughput of 1 op per SETTLE+1 cycles.
- No combinational path from inputs to outputs.

## Configuration
- `SYSU_NAND2_ARB_SELFTEST_EN` defined:
  - After reset, TEST runs vectors (A,B)=00,01,10,11 in order. Each vector uses the same hold/capture timing as a normal op: SETTLE+1 cycles per vector.
  - The result is compared to 1,1,1,0; any mismatch sets `FAIL` (sticky until `RST`).
  - `READY`=0, `GNT`=0, `VALID`=0 throughout; `REQ` is ignored.
  - Enters IDLE 4·(SETTLE+1) cycles after reset deasserts.
- Not defined: TEST state absent, `FAIL` tied 0, IDLE immediately after reset.

## Structure
- Package `sysu_arb_pkg`: state enum (`S_TEST`, `S_IDLE`, `S_SETTLE`) and self-test vector/expected constants (`NAND_EXP`=4'b0111, indexed by {A,B}).
- Sub-module `sysu_rr_pick` (combinational): `REQ`, `PTR` → one-hot grant plus encoded index.
- Shared gate: a single `sysu_nand2 #(GATE_DELAY)` instance driven from the operand regs.

## Test plan
- N=4, SETTLE=2, `REQ`=0100, A=1, B=1 → `GNT`=0100 for 2 cycles. Next cycle `VALID`=1, `Y_OUT`=0, `ID`=2.
- `REQ`=1111 held continuously, `PTR`=0 → grant order 0,1,2,3,0. A `VALID` every 3 cycles.
- `REQ`=1000 only, then dropped one cycle after grant → `VALID` still pulses with `ID`=3 at the same cycle.
- `RST` pulsed during SETTLE → no `VALID`, `GNT`=0. `READY` returns next cycle (macro off), or after 12 cycles (macro on, SETTLE=2).
- Macro on with a gate model forced to output 1 on 11 → `FAIL`=1 after the test window. IDLE is still entered and normal arbitration continues.
- SETTLE=1, alternating `REQ` 0001/0010 → back-to-back ops at 2-cycle spacing. `PTR` wraps 3→0 correctly when N=4.
